frame_collector: RTL and testbench
==================================

Name: frame_collector

Overview:
- Sink-side companion to the generator datapath.
- Captures the generator's output pixel stream into an on-chip frame buffer. That stream is valid-only, one pixel per valid beat, with no backpressure.
- Once a full frame is stored, replays it in capture order over a valid/ready handshake to a slower consumer (host readback / UART serializer).
- Absorbs the mismatch between the generator's free-running output and a stalling downstream, and accounts for any samples lost while the buffer is being drained.

Parameters:
- DATA_WIDTH, 16, pixel width (signed fixed point, passed through unmodified).
- FRAME_PIXELS, 169, pixels per frame (13x13 generator output).
- ADDR_WIDTH, 8, buffer address width; must satisfy 2^ADDR_WIDTH >= FRAME_PIXELS.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample strobe; no ready is returned.
- in_data  in  DATA_WIDTH  input sample (signed).
- out_valid  out  1  output beat available.
- out_ready  in  1  downstream accepts beat when high together with out_valid.
- out_data  out  DATA_WIDTH  output sample (signed).
- out_last  out  1  high with the final beat of a frame.
- frame_done  out  1  one-cycle pulse when a frame finishes capturing.
- busy  out  1  high while in drain state.
- overflow  out  1  sticky: at least one input sample was dropped.
- drop_count  out  16  saturating count of dropped input samples.

Behaviour:
- Reset (rst high at an edge):
  - state goes to S_CAPTURE; write and read pointers go to 0; skid entries are emptied.
  - out_valid=0, out_data=0, out_last=0, frame_done=0, busy=0, overflow=0, drop_count=0.
  - Reset mid-drain abandons the frame: out_valid is low in the cycle after the reset edge, and the partial frame is never emitted.
- Handshake:
  - A beat transfers on an edge where out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_last are held stable and out_valid stays high.
  - out_valid never drops without a transfer, except on reset.
- S_CAPTURE:
  - On each edge with in_valid, in_data is written at wr_ptr and wr_ptr increments.
  - The write at wr_ptr = FRAME_PIXELS-1 causes, at the same edge: wr_ptr <= 0, state <= S_DRAIN, frame_done <= 1 (for one cycle).
  - out_valid = 0 throughout S_CAPTURE.
- S_DRAIN:
  - busy = 1.
  - The buffer uses a registered read with 1-cycle latency, fronted by a 2-entry output skid so that full throughput is sustained.
  - Latency: if the last sample is captured at edge k, out_valid is high from edge k+2 onward.
  - With out_ready held high, all FRAME_PIXELS beats transfer on consecutive edges with no bubbles.
  - Beats are emitted in capture order, indices 0..FRAME_PIXELS-1; out_last=1 only on index FRAME_PIXELS-1.
  - The edge that transfers the out_last beat sets state <= S_CAPTURE and clears busy.
- Drops:
  - in_valid during S_DRAIN is discarded and not written.
  - Each drop sets overflow and increments drop_count; drop_count saturates at 16'hFFFF.
  - Both are cleared only by reset.
  - Drop boundaries: a sample arriving on the same edge as the out_last transfer is still dropped. A sample on the following edge is index 0 of the next frame.
- No arithmetic is applied; data is a bit-exact pass-through.
- No simultaneous read and write to the same buffer address can occur, since capture and drain are exclusive states.

Test Plan:
- Reset, then 169 consecutive in_valid beats with in_data = i (i = 0..168), out_ready=1:
  - frame_done pulses once at the edge after the last write;
  - out_valid rises 2 edges after the last capture;
  - 169 back-to-back beats 0..168 appear, out_last only on 168;
  - drop_count=0, overflow=0.
- Same frame with values -i, out_ready pattern 1,0,0,1 repeating:
  - the output sequence is exactly 0, -1, …, -168;
  - out_data and out_last are stable during every stall;
  - no duplicates, no gaps.
- Input with random 0–3 cycle gaps between in_valid, using values 16'h8000 + i:
  - the output is identical in order and value, confirming signed extremes pass bit-exact.
- During drain, 5 in_valid pulses with in_data = 16'h7FFF:
  - drop_count=5 and overflow=1;
  - no 7FFF appears in the frame;
  - a following full frame is captured and replayed correctly, while overflow stays 1.
- Assert rst for one cycle after 50 beats transferred:
  - next cycle out_valid=0, busy=0, drop_count=0, overflow=0;
  - a new frame of values 1000+i then replays 1000..1168 starting from index 0.
- Hold in_valid high during 70000 drain cycles with out_ready=0:
  - drop_count saturates at 16'hFFFF with no wrap;
  - out_data stays frozen on beat 0.

Source files
------------

// File: rtl/frame_collector.sv
// Frame buffer that captures one full frame from a free-running pixel stream and
// replays it in capture order over a valid/ready handshake, counting samples lost while draining.
module frame_collector #(
    parameter int DATA_WIDTH   = 16,
    parameter int FRAME_PIXELS = 169,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  overflow,
    output logic [15:0]           drop_count
);
    localparam int                    DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);
    localparam logic [ADDR_WIDTH:0]   FRAME_CNT = (ADDR_WIDTH + 1)'(FRAME_PIXELS);

    typedef enum logic {
        S_CAPTURE,
        S_DRAIN
    } state_e;

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH:0]   rdPtr_q, rdPtr_d;
    logic [ADDR_WIDTH-1:0] outIdx_q, outIdx_d;
    logic [DATA_WIDTH-1:0] rdData_q;
    logic                  rdValid_q, rdValid_d;
    logic [DATA_WIDTH-1:0] skid0_q, skid0_d;
    logic [DATA_WIDTH-1:0] skid1_q, skid1_d;
    logic [1:0]            skidCnt_q, skidCnt_d;
    logic                  frameDone_q, frameDone_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           dropCount_q, dropCount_d;

    logic       writeEn;
    logic       lastWrite;
    logic       popBeat;
    logic       lastBeat;
    logic       readEn;
    logic [2:0] occupancy;

    // A read is only issued when the skid still has room for it once the
    // in-flight read lands, so the two skid entries can never overrun.
    always_comb begin
        writeEn   = (state_q == S_CAPTURE) && in_valid;
        lastWrite = writeEn && (wrPtr_q == LAST_ADDR);
        popBeat   = out_valid && out_ready;
        lastBeat  = popBeat && (outIdx_q == LAST_ADDR);
        occupancy = {1'b0, skidCnt_q} + {2'b00, rdValid_q} - {2'b00, popBeat};
        readEn    = (state_q == S_DRAIN) && (rdPtr_q < FRAME_CNT) && (occupancy < 3'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CAPTURE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CAPTURE: if (lastWrite) state_d = S_DRAIN;
            S_DRAIN:   if (lastBeat)  state_d = S_CAPTURE;
            default:   state_d = S_CAPTURE;
        endcase
    end

    always_comb begin
        busy       = (state_q == S_DRAIN);
        out_valid  = (state_q == S_DRAIN) && (skidCnt_q != 2'd0);
        out_data   = skid0_q;
        out_last   = out_valid && (outIdx_q == LAST_ADDR);
        frame_done = frameDone_q;
        overflow   = overflow_q;
        drop_count = dropCount_q;
    end

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        outIdx_d    = outIdx_q;
        rdValid_d   = readEn;
        frameDone_d = lastWrite;
        overflow_d  = overflow_q;
        dropCount_d = dropCount_q;
        skid0_d     = skid0_q;
        skid1_d     = skid1_q;
        skidCnt_d   = skidCnt_q;

        if (writeEn) begin
            wrPtr_d = lastWrite ? '0 : wrPtr_q + 1'b1;
        end
        if (readEn) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (popBeat) begin
            outIdx_d = outIdx_q + 1'b1;
        end
        if (lastBeat) begin
            rdPtr_d  = '0;
            outIdx_d = '0;
        end

        // Skid entry 0 is always the head presented on out_data.
        case ({rdValid_q, popBeat})
            2'b10: begin
                if (skidCnt_q == 2'd0) begin
                    skid0_d = rdData_q;
                end else begin
                    skid1_d = rdData_q;
                end
                skidCnt_d = skidCnt_q + 2'd1;
            end
            2'b01: begin
                if (skidCnt_q == 2'd2) begin
                    skid0_d = skid1_q;
                end
                skidCnt_d = skidCnt_q - 2'd1;
            end
            2'b11: begin
                if (skidCnt_q == 2'd1) begin
                    skid0_d = rdData_q;
                end else begin
                    skid0_d = skid1_q;
                    skid1_d = rdData_q;
                end
            end
            default: ;
        endcase

        if ((state_q == S_DRAIN) && in_valid) begin
            overflow_d = 1'b1;
            if (dropCount_q != 16'hFFFF) begin
                dropCount_d = dropCount_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem[wrPtr_q] <= in_data;
        end
        if (readEn) begin
            rdData_q <= mem[rdPtr_q[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            outIdx_q    <= '0;
            rdValid_q   <= 1'b0;
            skid0_q     <= '0;
            skid1_q     <= '0;
            skidCnt_q   <= 2'd0;
            frameDone_q <= 1'b0;
            overflow_q  <= 1'b0;
            dropCount_q <= 16'd0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            outIdx_q    <= outIdx_d;
            rdValid_q   <= rdValid_d;
            skid0_q     <= skid0_d;
            skid1_q     <= skid1_d;
            skidCnt_q   <= skidCnt_d;
            frameDone_q <= frameDone_d;
            overflow_q  <= overflow_d;
            dropCount_q <= dropCount_d;
        end
    end

endmodule

// File: tb/tb_frame_collector.sv
// Randomized bench for frame_collector: a queue-based frame model predicts every
// output beat, drop count and status flag cycle by cycle.
module tb_frame_collector;
    localparam int FP = 169;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = 16'd0;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        frame_done;
    logic        busy;
    logic        overflow;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    logic [15:0] frameVals [FP];
    int          readyMode = 0;

    // Reference model state: pixels captured so far, and the frame being replayed.
    logic [15:0] capQ[$];
    logic [15:0] expQ[$];
    bit          armed     = 1'b0;
    bit          draining  = 1'b0;
    bit          fdExp     = 1'b0;
    int          drops     = 0;
    int          beatsDone = 0;
    int          waitCnt   = 0;

    frame_collector #(
        .DATA_WIDTH  (16),
        .FRAME_PIXELS(FP),
        .ADDR_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .frame_done(frame_done),
        .busy      (busy),
        .overflow  (overflow),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // The model looks at the inputs on the falling edge and decides what the
    // coming rising edge does, after checking the DUT against the current state.
    always @(negedge clk) begin
        bit wasDraining;
        bit captureDone;
        wasDraining = draining;
        captureDone = 1'b0;
        if (armed) begin
            checkOutput("busy", 32'(busy), 32'(draining));
            checkOutput("frameDone", 32'(frame_done), 32'(fdExp));
            checkOutput("dropCount", 32'(drop_count), 32'(drops));
            checkOutput("overflow", 32'(overflow), 32'(drops != 0));
            if (!draining) begin
                checkOutput("idleValid", 32'(out_valid), 32'd0);
            end else begin
                waitCnt++;
                if (beatsDone == 0) begin
                    checkOutput("latency", 32'(out_valid), 32'(waitCnt >= 3));
                end else begin
                    checkOutput("noGap", 32'(out_valid), 32'd1);
                end
                if (out_valid) begin
                    checkOutput("data", 32'(out_data), 32'(expQ[0]));
                    checkOutput("last", 32'(out_last), 32'(expQ.size() == 1));
                end
            end
        end
        if (rst) begin
            capQ.delete();
            expQ.delete();
            draining  = 1'b0;
            fdExp     = 1'b0;
            drops     = 0;
            beatsDone = 0;
            armed     = 1'b1;
        end else begin
            if (in_valid) begin
                if (!wasDraining) begin
                    capQ.push_back(in_data);
                    if (capQ.size() == FP) begin
                        expQ = capQ;
                        capQ.delete();
                        draining    = 1'b1;
                        captureDone = 1'b1;
                        waitCnt     = 0;
                        beatsDone   = 0;
                    end
                end else if (drops < 65535) begin
                    drops++;
                end
            end
            if (wasDraining && out_valid && out_ready) begin
                void'(expQ.pop_front());
                beatsDone++;
                if (expQ.size() == 0) draining = 1'b0;
            end
            fdExp = captureDone;
        end
    end

    initial begin
        int phase = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       out_ready = 1'b1;
                1:       out_ready = (phase % 4 == 0) || (phase % 4 == 3);
                default: out_ready = 1'b0;
            endcase
            phase++;
        end
    end

    task automatic applyStimulus(input int maxGap);
        for (int i = 0; i < FP; i++) begin
            in_valid = 1'b1;
            in_data  = frameVals[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (maxGap > 0 && i < FP - 1) begin
                int g;
                g = int'($urandom_range(maxGap, 0));
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (draining && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drainDone", 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstValid", 32'(out_valid), 32'd0);
        checkOutput("rstData", 32'(out_data), 32'd0);
        checkOutput("rstLast", 32'(out_last), 32'd0);
        checkOutput("rstFrameDone", 32'(frame_done), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstOverflow", 32'(overflow), 32'd0);
        checkOutput("rstDrops", 32'(drop_count), 32'd0);
        rst = 1'b0;

        $display("[TB] ramp frame, ready always high");
        for (int i = 0; i < FP; i++) frameVals[i] = 16'(i);
        readyMode = 0;
        applyStimulus(0);
        waitDrain(1000);
        checkOutput("t1Drops", 32'(drop_count), 32'd0);
        checkOutput("t1Overflow", 32'(overflow), 32'd0);

        $display("[TB] negative ramp, ready pattern 1,0,0,1");
        for (int i = 0; i < FP; i++) frameVals[i] = 16'(-i);
        readyMode = 1;
        applyStimulus(0);
        waitDrain(2000);

        $display("[TB] signed extremes with random input gaps");
        for (int i = 0; i < FP; i++) frameVals[i] = 16'h8000 + 16'(i);
        readyMode = 0;
        applyStimulus(3);
        waitDrain(1000);

        $display("[TB] drops during drain, including the last-beat edge");
        for (int i = 0; i < FP; i++) frameVals[i] = 16'(i * 3);
        applyStimulus(0);
        repeat (4) begin
            in_valid = 1'b1;
            in_data  = 16'h7FFF;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            repeat (3) begin
                @(posedge clk);
                #1;
            end
        end
        n = 0;
        while (!(out_valid && out_last) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b1;
        in_data  = 16'h7FFF;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("t4Drops", 32'(drop_count), 32'd5);
        checkOutput("t4Overflow", 32'(overflow), 32'd1);
        checkOutput("t4Busy", 32'(busy), 32'd0);
        for (int i = 0; i < FP; i++) frameVals[i] = 16'(200 + i * 7);
        applyStimulus(0);
        waitDrain(1000);
        checkOutput("t4StickyOverflow", 32'(overflow), 32'd1);

        $display("[TB] reset in the middle of a drain");
        for (int i = 0; i < FP; i++) frameVals[i] = 16'(500 + i);
        applyStimulus(0);
        n = 0;
        while (beatsDone < 50 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midRstValid", 32'(out_valid), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstDrops", 32'(drop_count), 32'd0);
        checkOutput("midRstOverflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < FP; i++) frameVals[i] = 16'(1000 + i);
        applyStimulus(0);
        waitDrain(1000);

        $display("[TB] drop counter saturation with downstream stalled");
        for (int i = 0; i < FP; i++) frameVals[i] = 16'(3000 + i);
        readyMode = 2;
        applyStimulus(0);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        repeat (70000) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("satCount", 32'(drop_count), 32'h0000FFFF);
        checkOutput("satFrozenData", 32'(out_data), 32'd3000);
        readyMode = 0;
        waitDrain(1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
